// File: rtl/sram_bank_ret_wrapper.sv
// -----------------------------------------------------------------------------
// sram_bank_ret_wrapper
//
// One slave memory port spread over NumMacros equal-depth banks. Each bank has
// its own retention FSM (ACTIVE / RETENTIVE / WAKEUP). A request is granted
// only when its target bank is ACTIVE and is not being put into retention in
// the same cycle. Other banks stay fully usable while one sleeps. Reads return
// after 1 cycle (OutputReg=0) or 2 cycles (OutputReg=1) and are fully
// pipelined.
//
// Ports
//   clk_i            clock, all state on rising edge
//   rst_i            asynchronous active-high reset
//   req_i / gnt_o    request / combinational grant
//   we_i             1 = write, 0 = read
//   addr_i           word address, MSBs select the bank
//   wdata_i, be_i    write data and byte enables
//   set_retentive_i  per-bank retention request
//   ret_state_o      per-bank "not ACTIVE" flag (registered)
//   rvalid_o         read data valid (one cycle per accepted read)
//   rdata_o          read data, holds the last read value between reads
// -----------------------------------------------------------------------------
module sram_bank_ret_wrapper #(
    parameter int NumWords     = 1024,
    parameter int DataWidth    = 32,
    parameter int NumMacros    = 2,
    parameter int WakeupCycles = 4,
    parameter int OutputReg    = 0,
    parameter int AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int BeWidth      = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic [NumMacros-1:0] set_retentive_i,
    output logic [NumMacros-1:0] ret_state_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int BankBits     = (NumMacros > 1) ? $clog2(NumMacros) : 1;
    localparam int WordsPerBank = NumWords / NumMacros;
    localparam int RowBits      = (WordsPerBank > 1) ? $clog2(WordsPerBank) : 1;
    localparam logic [7:0] WakeLoad = 8'(WakeupCycles - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_RETENTIVE = 2'd1,
        ST_WAKEUP    = 2'd2
    } bank_state_e;

    logic [BankBits-1:0]  bank_sel;
    logic [RowBits-1:0]   row;
    logic [NumMacros-1:0] bank_active;
    logic [DataWidth-1:0] bank_rdata [NumMacros];

    assign row = addr_i[RowBits-1:0];

    generate
        if (NumMacros > 1) begin : g_sel_multi
            assign bank_sel = addr_i[AddrWidth-1 -: BankBits];
        end else begin : g_sel_single
            assign bank_sel = '0;
        end
    endgenerate

    // Retention wins over a request arriving in the same cycle.
    assign gnt_o = req_i & bank_active[bank_sel] & ~set_retentive_i[bank_sel];

    // -------------------------------------------------------------------------
    // Per-bank retention FSM and storage
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NumMacros; gi++) begin : g_bank
            bank_state_e          state_reg, state_next;
            logic [7:0]           wake_cnt_reg, wake_cnt_next;
            logic                 ret_state_reg;
            logic                 bank_en;
            logic [DataWidth-1:0] mem [WordsPerBank];
            logic [DataWidth-1:0] rdata_reg;

            assign bank_en = gnt_o && (bank_sel == BankBits'(gi));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_reg     <= ST_ACTIVE;
                    wake_cnt_reg  <= 8'd0;
                    ret_state_reg <= 1'b0;
                end else begin
                    state_reg     <= state_next;
                    wake_cnt_reg  <= wake_cnt_next;
                    // Registered copy of "not ACTIVE" for the state being entered.
                    ret_state_reg <= (state_next != ST_ACTIVE);
                end
            end

            always_comb begin
                state_next    = state_reg;
                wake_cnt_next = wake_cnt_reg;
                case (state_reg)
                    ST_ACTIVE: begin
                        if (set_retentive_i[gi]) begin
                            state_next = ST_RETENTIVE;
                        end
                    end
                    ST_RETENTIVE: begin
                        if (!set_retentive_i[gi]) begin
                            state_next    = ST_WAKEUP;
                            wake_cnt_next = WakeLoad;
                        end
                    end
                    ST_WAKEUP: begin
                        if (set_retentive_i[gi]) begin
                            state_next    = ST_RETENTIVE;
                            wake_cnt_next = 8'd0;
                        end else if (wake_cnt_reg == 8'd0) begin
                            state_next = ST_ACTIVE;
                        end else begin
                            wake_cnt_next = wake_cnt_reg - 8'd1;
                        end
                    end
                    default: begin
                        state_next    = ST_ACTIVE;
                        wake_cnt_next = 8'd0;
                    end
                endcase
            end

            // Array with registered read; contents are deliberately not reset.
            always_ff @(posedge clk_i) begin
                if (bank_en) begin
                    if (we_i) begin
                        for (int k = 0; k < BeWidth; k++) begin
                            if (be_i[k]) begin
                                mem[row][k*8 +: 8] <= wdata_i[k*8 +: 8];
                            end
                        end
                    end else begin
                        rdata_reg <= mem[row];
                    end
                end
            end

            assign bank_active[gi] = (state_reg == ST_ACTIVE);
            assign ret_state_o[gi] = ret_state_reg;
            assign bank_rdata[gi]  = rdata_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read return path
    // -------------------------------------------------------------------------
    logic                 rd_valid_reg;
    logic [BankBits-1:0]  rd_bank_reg;
    logic [DataWidth-1:0] rd_data;
    logic [DataWidth-1:0] rdata_hold_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_reg <= 1'b0;
            rd_bank_reg  <= '0;
        end else begin
            rd_valid_reg <= gnt_o & ~we_i;
            if (gnt_o && !we_i) begin
                rd_bank_reg <= bank_sel;
            end
        end
    end

    // The bank's own data register was loaded at grant time, so a bank going
    // into retention right after a granted read cannot corrupt that read.
    assign rd_data = bank_rdata[rd_bank_reg];

    // Holds the last returned word between reads; doubles as the extra
    // output stage when OutputReg=1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_hold_reg <= '0;
        end else if (rd_valid_reg) begin
            rdata_hold_reg <= rd_data;
        end
    end

    generate
        if (OutputReg != 0) begin : g_out_reg
            logic rvalid_out_reg;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rvalid_out_reg <= 1'b0;
                end else begin
                    rvalid_out_reg <= rd_valid_reg;
                end
            end
            assign rvalid_o = rvalid_out_reg;
            assign rdata_o  = rdata_hold_reg;
        end else begin : g_out_direct
            assign rvalid_o = rd_valid_reg;
            assign rdata_o  = rd_valid_reg ? rd_data : rdata_hold_reg;
        end
    endgenerate

endmodule
